// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, throttled on almost-full.
// Define FIFO_WR_ARB_BURST_EN to hold a grant for up to MAX_BURST words; otherwise one word per grant.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst_L,
    input  logic [NUM_REQ-1:0]         i_Req_DV,
    input  logic [NUM_REQ*WIDTH-1:0]   i_Req_Data,
    output logic [NUM_REQ-1:0]         o_Req_Ack,
    output logic [NUM_REQ-1:0]         o_Grant,
    output logic                       o_Busy,
    output logic                       o_Wr_DV,
    output logic [WIDTH-1:0]           o_Wr_Data,
    input  logic                       i_Full,
    input  logic                       i_AF_Flag
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || MAX_BURST < 1) begin : g_bad_param
        $error("fifo_wr_arbiter: NUM_REQ must be >= 2 and MAX_BURST >= 1");
    end

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e             state_q, state_d;
    logic [PtrW-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               wr_dv_q, wr_dv_d;
    logic [WIDTH-1:0]   wr_data_q, wr_data_d;

    logic               stall;
    logic               acked;
    logic               last_ack;
    logic               owner_dv;
    logic [WIDTH-1:0]   owner_data;
    logic [NUM_REQ-1:0] ack;
    logic               pick_found;
    logic [PtrW-1:0]    pick_idx;

    assign stall    = i_AF_Flag | i_Full;
    assign owner_dv = |(grant_q & i_Req_DV);
    assign ack      = (state_q == StGrant && !stall) ? (grant_q & i_Req_DV) : '0;
    assign acked    = |ack;

    always_comb begin
        owner_data = '0;
        for (int unsigned n = 0; n < NUM_REQ; n++) begin
            if (grant_q[n]) begin
                owner_data = owner_data | i_Req_Data[n*WIDTH +: WIDTH];
            end
        end
    end

    // Round-robin search starting one past the last owner, wrapping around.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (32'(ptr_q) + i) % NUM_REQ;
            if (!pick_found && i_Req_DV[idx]) begin
                pick_found = 1'b1;
                pick_idx   = PtrW'(idx);
            end
        end
    end

`ifdef FIFO_WR_ARB_BURST_EN
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    logic [CntW-1:0] burst_q, burst_d;

    assign last_ack = acked && (burst_q == CntW'(MAX_BURST - 1));

    always_comb begin
        burst_d = burst_q;
        if (state_q == StIdle) begin
            burst_d = '0;
        end else if (acked) begin
            burst_d = burst_q + 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    assign last_ack = acked;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        wr_dv_d   = 1'b0;
        wr_data_d = wr_data_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    ptr_d             = pick_idx;
                    state_d           = StGrant;
                end
            end
            StGrant: begin
                if (acked) begin
                    wr_dv_d   = 1'b1;
                    wr_data_d = owner_data;
                end
                // A dropped DV releases even while stalled.
                if (!owner_dv || last_ack) begin
                    grant_d = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= StIdle;
            ptr_q     <= PtrW'(NUM_REQ - 1);
            grant_q   <= '0;
            wr_dv_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            wr_dv_q   <= wr_dv_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign o_Req_Ack = ack;
    assign o_Grant   = grant_q;
    assign o_Busy    = (state_q == StGrant);
    assign o_Wr_DV   = wr_dv_q;
    assign o_Wr_Data = wr_data_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a depth-4 FIFO occupancy model (AF at 3).
// Expectations follow FIFO_WR_ARB_BURST_EN: burst of 4 when defined, single word otherwise.
module tb_fifo_wr_arbiter;

`ifdef FIFO_WR_ARB_BURST_EN
    localparam int BurstLen = 4;
    localparam int ExpN     = 4;
`else
    localparam int BurstLen = 1;
    localparam int ExpN     = 3;
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_dv;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        busy;
    logic        wr_dv;
    logic [7:0]  wr_data;
    logic        full;
    logic        af;
    logic        rd_en;

    int fifo_cnt;
    int ovf;
    int checks;
    int errors;
    int k[4];
    int base[4];
    logic [7:0] wr_log[$];
    int grant_log[$];
    int ack_log[$];
    int gap_log[$];

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .WIDTH     (8),
        .MAX_BURST (4)
    ) dut (
        .i_Clk      (clk),
        .i_Rst_L    (rst_n),
        .i_Req_DV   (req_dv),
        .i_Req_Data (req_data),
        .o_Req_Ack  (ack),
        .o_Grant    (grant),
        .o_Busy     (busy),
        .o_Wr_DV    (wr_dv),
        .o_Wr_Data  (wr_data),
        .i_Full     (full),
        .i_AF_Flag  (af)
    );

    assign full = (fifo_cnt >= 4);
    assign af   = (fifo_cnt >= 3);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO occupancy model: write lands on the edge after o_Wr_DV rises.
    initial begin
        fifo_cnt = 0;
        ovf      = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                fifo_cnt <= 0;
            end else begin
                if (wr_dv) begin
                    wr_log.push_back(wr_data);
                    if (fifo_cnt >= 4) ovf++;
                end
                fifo_cnt <= fifo_cnt + (wr_dv ? 1 : 0) - ((rd_en && fifo_cnt > 0) ? 1 : 0);
            end
        end
    end

    // Grant monitor: order, acks per grant, idle cycles before each grant.
    initial begin
        logic [3:0] prev_gnt;
        int cur_acks;
        int gap;
        prev_gnt = '0;
        cur_acks = 0;
        gap      = 0;
        forever begin
            @(negedge clk);
            if (grant !== prev_gnt) begin
                if (prev_gnt != 0) ack_log.push_back(cur_acks);
                if (grant != 0) begin
                    grant_log.push_back(onehot_idx(grant));
                    gap_log.push_back(gap);
                    cur_acks = 0;
                end
                gap = 0;
            end
            if (grant == 0) gap++;
            if (ack != 0) cur_acks++;
            prev_gnt = grant;
        end
    end

    function automatic int onehot_idx(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_words();
        for (int n = 0; n < 4; n++) req_data[n*8 +: 8] = 8'(base[n] + k[n]);
    endtask

    task automatic clear_logs();
        wr_log.delete();
        grant_log.delete();
        ack_log.delete();
        gap_log.delete();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req_dv   = '0;
        req_data = '0;
        rd_en    = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        clear_logs();
    endtask

    // Hold data stable until acked, then advance that requester's word.
    task automatic stream(input int max_cyc, input int stop_at);
        logic [3:0] ack_s;
        for (int c = 0; c < max_cyc; c++) begin
            if (stop_at > 0 && grant_log.size() >= stop_at) break;
            ack_s = ack;
            tick();
            for (int n = 0; n < 4; n++) if (ack_s[n]) k[n]++;
            drive_words();
            #1;
        end
    endtask

    initial begin
        bit got;
        checks = 0;
        errors = 0;
        rst_n    = 1'b0;
        req_dv   = '0;
        req_data = '0;
        rd_en    = 1'b1;

        // 1: reset values, then a single word from requester 2
        repeat (2) tick();
        chk("rst_grant", grant, 4'b0000);
        chk("rst_ack", ack, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_dv", wr_dv, 1'b0);
        chk("rst_wr_data", wr_data, 8'h00);
        rst_n = 1'b1;
        clear_logs();
        req_dv[2]          = 1'b1;
        req_data[23:16]    = 8'h5A;
        #1;
        chk("t1_idle_ack", ack, 4'b0000);
        chk("t1_idle_grant", grant, 4'b0000);
        tick();
        chk("t1_grant", grant, 4'b0100);
        chk("t1_busy", busy, 1'b1);
        chk("t1_ack", ack, 4'b0100);
        tick();
        chk("t1_wr_dv", wr_dv, 1'b1);
        chk("t1_wr_data", wr_data, 8'h5A);
`ifdef FIFO_WR_ARB_BURST_EN
        chk("t1_grant_held", grant, 4'b0100);
`else
        chk("t1_grant_rel", grant, 4'b0000);
`endif
        req_dv[2] = 1'b0;
        #1;
        chk("t1_ack_done", ack, 4'b0000);
        tick();
        chk("t1_end_grant", grant, 4'b0000);
        chk("t1_end_busy", busy, 1'b0);
        chk("t1_end_wr_dv", wr_dv, 1'b0);

        // 2/3: all four stream with the FIFO drained every cycle
        do_reset();
        rd_en = 1'b1;
        for (int n = 0; n < 4; n++) begin
            k[n]    = 0;
            base[n] = n * 'h40;
        end
        drive_words();
        req_dv = 4'b1111;
        #1;
        stream(200, 5);
        req_dv = '0;
        repeat (4) tick();
        chk("t2_grants_seen", (grant_log.size() >= 5), 1);
        for (int g = 0; g < 5; g++) chk($sformatf("t2_order%0d", g), grant_log[g], g % 4);
        for (int g = 0; g < 4; g++) chk($sformatf("t2_acks%0d", g), ack_log[g], BurstLen);
        for (int g = 1; g < 5; g++) chk($sformatf("t2_gap%0d", g), gap_log[g], 1);
        for (int g = 0; g < 4; g++) begin
            for (int j = 0; j < BurstLen; j++) begin
                chk($sformatf("t2_wr_g%0d_w%0d", g, j), wr_log[g*BurstLen + j], g * 'h40 + j);
            end
        end

        // 4: no reads, requester 1 fills the FIFO until throttled
        do_reset();
        for (int n = 0; n < 4; n++) begin
            k[n]    = 0;
            base[n] = 0;
        end
        base[1] = 'h10;
        drive_words();
        req_dv = 4'b0010;
        #1;
        stream(30, 0);
        chk("t4_nwrites", wr_log.size(), ExpN);
        for (int i = 0; i < ExpN; i++) chk($sformatf("t4_wr%0d", i), wr_log[i], 'h10 + i);
        chk("t4_overflow", ovf, 0);
        chk("t4_fifo_cnt", fifo_cnt, ExpN);
        chk("t4_stall_ack", ack, 4'b0000);
        chk("t4_stall_wr_dv", wr_dv, 1'b0);
        chk("t4_stall_grant", grant, 4'b0010);
        chk("t4_stall_busy", busy, 1'b1);
        rd_en = 1'b1;
        repeat (ExpN - 2) tick();
        rd_en = 1'b0;
        chk("t4_drained", fifo_cnt, 2);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            if (ack[1]) got = 1'b1;
            else tick();
        end
        chk("t4_ack_after_drain", got, 1'b1);
        tick();
        chk("t4_next_wr_dv", wr_dv, 1'b1);
        chk("t4_next_wr_data", wr_data, 8'h10 + 8'(ExpN));
        req_dv = '0;

        // 5: owner drops DV while requester 0 waits
        do_reset();
        rd_en          = 1'b1;
        req_dv[3]      = 1'b1;
        req_data[31:24] = 8'hA0;
        #1;
        chk("t5_idle_grant", grant, 4'b0000);
        tick();
        chk("t5_grant3", grant, 4'b1000);
        req_dv[0]     = 1'b1;
        req_data[7:0] = 8'h01;
        #1;
        chk("t5_ack3", ack, 4'b1000);
        tick();
`ifdef FIFO_WR_ARB_BURST_EN
        req_data[31:24] = 8'hA1;
        #1;
        chk("t5_ack3_second", ack, 4'b1000);
        tick();
        req_dv[3] = 1'b0;
        #1;
        chk("t5_drop_ack", ack, 4'b0000);
        chk("t5_drop_grant", grant, 4'b1000);
        chk("t5_wr_a1", wr_data, 8'hA1);
        tick();
`else
        req_dv[3] = 1'b0;
`endif
        chk("t5_bubble_grant", grant, 4'b0000);
        chk("t5_bubble_busy", busy, 1'b0);
        tick();
        chk("t5_grant0", grant, 4'b0001);
        req_dv = '0;

        // 6: reset mid-burst, then requesters 0 and 2 contend
        do_reset();
        rd_en          = 1'b1;
        req_dv[1]      = 1'b1;
        req_data[15:8] = 8'h77;
        tick();
        chk("t6_grant1", grant, 4'b0010);
        tick();
        chk("t6_wr_dv_before", wr_dv, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_grant", grant, 4'b0000);
        chk("t6_rst_ack", ack, 4'b0000);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_wr_dv", wr_dv, 1'b0);
        chk("t6_rst_wr_data", wr_data, 8'h00);
        req_dv = 4'b0101;
        tick();
        rst_n = 1'b1;
        #1;
        chk("t6_post_idle", grant, 4'b0000);
        tick();
        chk("t6_first_winner", grant, 4'b0001);
        req_dv = '0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
